wb_write_queue: RTL and testbench
=================================

// Module: wb_write_queue
// PURPOSE
//  Write-back initiator for the 16x16 register file: buffers completed results from the ALU and
//  memory-load producers in an in-order queue and drives exactly one register-file write per cycle
//  on DstReg/WriteReg/DstData. Exports a per-register pending mask so decode can stall on
//  not-yet-committed destinations. Sits between the execute/memory stages and the register file.
// PARAMETERS
//  DEPTH       4   queue entries; power of two, >= 2
//  PTR_W       2   log2(DEPTH); pointer width (count is PTR_W+1 bits)
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  mem_valid  in   1   load result offered
//  mem_dst    in   4   load destination register
//  mem_data   in   16  load result
//  mem_ready  out  1   queue accepts mem entry this cycle
//  alu_valid  in   1   ALU result offered
//  alu_dst    in   4   ALU destination register
//  alu_data   in   16  ALU result
//  alu_ready  out  1   queue accepts alu entry this cycle
//  DstReg     out  4   register-file write address (head entry)
//  WriteReg   out  1   register-file write enable
//  DstData    out  16  register-file write data
//  pending    out  16  bit r = 1 while any queued entry targets register r
//  count      out  3   occupied entries (PTR_W+1 bits)
// BEHAVIOUR
//  - Reset: count=0, rd/wr pointers=0, all entry valid bits 0; outputs WriteReg=0, DstReg=0,
//    DstData=0, pending=0, count=0. Reset mid-operation discards every queued entry; no write issues.
//  - Handshake: entry transfers on posedge when valid && ready. Producer holds valid/dst/data
//    stable until accepted. ready never depends on the same port's valid.
//  - Drain: register file always accepts, so when count!=0 the head is presented combinationally
//    (WriteReg=1, DstReg/DstData = head) and pops at the next posedge. When count==0 outputs are 0.
//  - Free slots: free = DEPTH - count + (count!=0), accounting for this cycle's unconditional pop.
//    mem_ready = (free >= 1); alu_ready = (free >= 2) || (free >= 1 && !mem_valid).
//  - Both accepted same cycle: mem entry enqueued first (older), alu entry second.
//  - Latency: entry accepted at edge N -> WriteReg=1 for it during cycle N+1 if it is head ->
//    commits at edge N+1. Back-to-back writes every cycle when occupied.
//  - Ordering: strict FIFO; two entries to the same register commit in enqueue order (last wins).
//  - Pointers wrap modulo DEPTH; count += accepts - pop, never exceeds DEPTH nor underflows.
//  - pending: OR over valid entries of one-hot(dst); bit clears the cycle after its last entry pops.
//    Entry accepted at edge N sets its bit from cycle N+1.
//  - Full (count==DEPTH) with head popping: free=1, one producer may still enter (mem first).
// CONFIGURATION
//  WB_DROP_R0_EN defined: entries with dst==0 are accepted (ready/handshake unchanged) but not
//    stored; count, pending and WriteReg unaffected; register 0 never written.
//  WB_DROP_R0_EN undefined: register 0 is an ordinary destination, queued and written like any other.
// TESTING
//  1 rst=1 two cycles mid-stream with 3 entries queued -> next cycle count=0, WriteReg=0, pending=0.
//  2 empty; alu_valid dst=5 data=16'hBEEF one cycle -> next cycle WriteReg=1 DstReg=5
//    DstData=16'hBEEF pending=16'h0020; following cycle WriteReg=0 pending=0.
//  3 empty; mem(dst=3,16'h1111) and alu(dst=3,16'h2222) same cycle -> writes R3=1111 then R3=2222
//    on consecutive cycles; pending[3]=1 for both cycles.
//  4 hold both valids constantly, DEPTH=4 -> count saturates at 4, never 5; mem_ready=1 and
//    alu_ready=0 each full cycle; one write per cycle sustained; no entry lost or duplicated.
//  5 count=4, mem_valid=0, alu_valid=1 -> alu_ready=1, accepted; count stays 4.
//  6 WB_DROP_R0_EN: alu dst=0 data=16'h1234 -> alu_ready=1, count stays 0, WriteReg never 1;
//    without macro -> R0 written with 16'h1234 one cycle later.

Source files
------------

// File: rtl/wb_write_queue.sv
// In-order write-back queue feeding the 16x16 register file: one commit per cycle from the head,
// per-register pending mask for decode stalls. Optional WB_DROP_R0_EN discards writes to register 0.
module wb_write_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [3:0]  mem_dst,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [3:0]  alu_dst,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    output logic [3:0]  DstReg,
    output logic        WriteReg,
    output logic [15:0] DstData,
    output logic [15:0] pending,
    output logic [PTR_W:0] count
);
    localparam int CW = PTR_W + 1;

    logic [3:0]       dst_q  [DEPTH];
    logic [15:0]      data_q [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, alu_slot;
    logic [CW-1:0]    count_q, count_d, free;
    logic             pop, mem_acc, alu_acc, mem_store, alu_store;

    // Head always commits when present, so its slot counts as free this cycle.
    assign pop       = (count_q != '0);
    assign free      = CW'(DEPTH) - count_q + CW'(pop);
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = (free >= CW'(2)) || ((free >= CW'(1)) && !mem_valid);
    assign mem_acc   = mem_valid && mem_ready;
    assign alu_acc   = alu_valid && alu_ready;

`ifdef WB_DROP_R0_EN
    assign mem_store = mem_acc && (mem_dst != 4'd0);
    assign alu_store = alu_acc && (alu_dst != 4'd0);
`else
    assign mem_store = mem_acc;
    assign alu_store = alu_acc;
`endif

    // mem is the older of two same-cycle entries, so alu lands one slot behind it.
    assign alu_slot = wr_ptr_q + PTR_W'(mem_store);

    always_comb begin
        vld_d    = vld_q;
        rd_ptr_d = rd_ptr_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (mem_store) vld_d[wr_ptr_q] = 1'b1;
        if (alu_store) vld_d[alu_slot] = 1'b1;
        wr_ptr_d = wr_ptr_q + PTR_W'(mem_store) + PTR_W'(alu_store);
        count_d  = count_q + CW'(mem_store) + CW'(alu_store) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_store) begin
            dst_q[wr_ptr_q]  <= mem_dst;
            data_q[wr_ptr_q] <= mem_data;
        end
        if (alu_store) begin
            dst_q[alu_slot]  <= alu_dst;
            data_q[alu_slot] <= alu_data;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (vld_q[i]) pending[dst_q[i]] = 1'b1;
    end

    assign WriteReg = pop;
    assign DstReg   = pop ? dst_q[rd_ptr_q]  : 4'd0;
    assign DstData  = pop ? data_q[rd_ptr_q] : 16'd0;
    assign count    = count_q;
endmodule

// File: tb/tb_wb_write_queue.sv
// Bench for wb_write_queue: queue-based reference model checked every cycle plus directed scenarios.
module tb_wb_write_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_dst, alu_dst;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready, WriteReg;
    logic [3:0]  DstReg;
    logic [15:0] DstData, pending;
    logic [2:0]  count;

    int n_chk = 0;
    int n_fail = 0;

    wb_write_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_dst(mem_dst), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_dst(alu_dst), .alu_data(alu_data), .alu_ready(alu_ready),
        .DstReg(DstReg), .WriteReg(WriteReg), .DstData(DstData), .pending(pending), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain FIFO of (dst,data) pairs.
    typedef struct { logic [3:0] d; logic [15:0] v; } ent_t;
    ent_t q[$];
    bit started = 0;

    function automatic int free_slots(int sz);
        return DEPTH - sz + ((sz != 0) ? 1 : 0);
    endfunction

    function automatic bit drop(logic [3:0] d);
`ifdef WB_DROP_R0_EN
        return d == 4'd0;
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        int f;
        bit mr, ar;
        started = 1;
        if (rst) q.delete();
        else begin
            f  = free_slots(q.size());
            mr = (f >= 1);
            ar = (f >= 2) || (f >= 1 && !mem_valid);
            if (q.size() > 0) void'(q.pop_front());
            if (mem_valid && mr && !drop(mem_dst)) q.push_back('{mem_dst, mem_data});
            if (alu_valid && ar && !drop(alu_dst)) q.push_back('{alu_dst, alu_data});
        end
    end

    always @(negedge clk) begin
        logic [15:0] pm;
        int f;
        if (started) begin
            pm = '0;
            foreach (q[i]) pm[q[i].d] = 1'b1;
            f = free_slots(q.size());
            chk("m_count", 32'(count), 32'(q.size()));
            chk("m_pending", 32'(pending), 32'(pm));
            chk("m_write", 32'(WriteReg), 32'(q.size() != 0));
            chk("m_dst", 32'(DstReg), (q.size() != 0) ? 32'(q[0].d) : 32'd0);
            chk("m_data", 32'(DstData), (q.size() != 0) ? 32'(q[0].v) : 32'd0);
            chk("m_mready", 32'(mem_ready), 32'(f >= 1));
            chk("m_aready", 32'(alu_ready), 32'((f >= 2) || (f >= 1 && !mem_valid)));
        end
    end

    task automatic drv(input logic mv, input logic [3:0] md, input logic [15:0] mdat,
                       input logic av, input logic [3:0] ad, input logic [15:0] adat);
        mem_valid = mv; mem_dst = md; mem_data = mdat;
        alu_valid = av; alu_dst = ad; alu_data = adat;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic probe();
        @(negedge clk); #1;
    endtask

    initial begin
        logic mr, ar;
        logic [3:0]  md, ad;
        logic [15:0] mv, av;
        drv(0, 0, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        probe();
        chk("rst_count", 32'(count), 0);
        chk("rst_write", 32'(WriteReg), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_dstdata", 32'({DstReg, DstData}), 0);
        tick();

        // single ALU write
        drv(0, 0, 0, 1, 4'd5, 16'hBEEF);
        tick(); drv(0, 0, 0, 0, 0, 0);
        probe();
        chk("t2_write", 32'(WriteReg), 1);
        chk("t2_dst", 32'(DstReg), 5);
        chk("t2_data", 32'(DstData), 32'hBEEF);
        chk("t2_pending", 32'(pending), 32'h0020);
        tick(); probe();
        chk("t2_write_off", 32'(WriteReg), 0);
        chk("t2_pending_off", 32'(pending), 0);
        tick();

        // same-cycle pair to one register: mem is older
        drv(1, 4'd3, 16'h1111, 1, 4'd3, 16'h2222);
        tick(); drv(0, 0, 0, 0, 0, 0);
        probe();
        chk("t3_first", 32'({WriteReg, DstReg, DstData}), 32'h1_3_1111);
        chk("t3_pend1", 32'(pending), 32'h0008);
        tick(); probe();
        chk("t3_second", 32'({WriteReg, DstReg, DstData}), 32'h1_3_2222);
        chk("t3_pend2", 32'(pending), 32'h0008);
        tick(); probe();
        chk("t3_idle", 32'(WriteReg), 0);
        tick();

        // sustained both-valid pressure; values advance only when accepted
        md = 4'd1; mv = 16'hA000; ad = 4'd8; av = 16'hB000;
        drv(1, md, mv, 1, ad, av);
        for (int i = 0; i < 14; i++) begin
            probe();
            mr = mem_ready; ar = alu_ready;
            chk("t4_cap", 32'(count > 3'd4), 0);
            if (count == 3'd4) chk("t4_full_rdy", 32'({mr, ar}), 32'b10);
            if (i == 4) chk("t4_sat", 32'(count), 4);
            tick();
            if (mr) begin md = md + 4'd1; mv = mv + 16'd1; end
            if (ar) begin ad = ad + 4'd1; av = av + 16'd1; end
            drv(1, md, mv, 1, ad, av);
        end
        drv(0, 0, 0, 0, 0, 0);
        repeat (6) tick();

        // full with alu-only offer
        drv(1, 4'd1, 16'h0101, 1, 4'd2, 16'h0202); tick();
        drv(1, 4'd3, 16'h0303, 1, 4'd4, 16'h0404); tick();
        drv(1, 4'd5, 16'h0505, 1, 4'd6, 16'h0606); tick();
        drv(0, 0, 0, 1, 4'd9, 16'h5555);
        probe();
        chk("t5_count_full", 32'(count), 4);
        chk("t5_alu_ready", 32'(alu_ready), 1);
        tick(); drv(0, 0, 0, 0, 0, 0);
        probe();
        chk("t5_count_stays", 32'(count), 4);
        repeat (6) tick();

        // reset mid-stream with 3 queued
        drv(1, 4'd1, 16'hA1A1, 1, 4'd2, 16'hA2A2); tick();
        drv(1, 4'd3, 16'hA3A3, 1, 4'd4, 16'hA4A4); tick();
        drv(0, 0, 0, 0, 0, 0);
        probe();
        chk("t1_count3", 32'(count), 3);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        probe();
        chk("t1_count", 32'(count), 0);
        chk("t1_write", 32'(WriteReg), 0);
        chk("t1_pending", 32'(pending), 0);
        tick();

        // register 0 destination
        drv(0, 0, 0, 1, 4'd0, 16'h1234);
        probe();
        chk("t6_ready", 32'(alu_ready), 1);
        tick(); drv(0, 0, 0, 0, 0, 0);
        probe();
`ifdef WB_DROP_R0_EN
        chk("t6_count", 32'(count), 0);
        chk("t6_write", 32'(WriteReg), 0);
`else
        chk("t6_write", 32'({WriteReg, DstReg, DstData}), 32'h1_0_1234);
`endif
        tick(); probe();
        chk("t6_after", 32'(WriteReg), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
